ddr3_avl_arbiter: RTL and testbench
===================================

// Module: ddr3_avl_arbiter
// PURPOSE
//  N-port Avalon-MM arbiter for the DDR3 controller local interface; replaces the fixed
//  read-has-priority mux between read and write masters. Round-robin command grant,
//  write-burst lock, tagged routing of read data back to the issuing port.
//  Sits between frame read/write/test masters and the DDR3 UniPHY avl port, ddr3_clk domain.
// PARAMETERS
//  NUM_PORTS   2    number of requesting masters (2..8)
//  DATA_WIDTH  128  avl data width
//  ADDR_WIDTH  26   avl word address width
//  SIZE_WIDTH  3    avl burst size width (beats)
//  TAG_DEPTH   16   outstanding read commands tracked (power of 2)
// PORTS
//  ddr3_clk              in   1              clock
//  ddr3_reset_n          in   1              async active-low reset
//  port_read             in   NUM_PORTS      per-port read command request
//  port_write            in   NUM_PORTS      per-port write beat request
//  port_addr             in   NUM_PORTS*ADDR_WIDTH  per-port address (port i at [i*AW +: AW])
//  port_size             in   NUM_PORTS*SIZE_WIDTH  per-port burst size
//  port_wr_data          in   NUM_PORTS*DATA_WIDTH  per-port write data
//  port_ready            out  NUM_PORTS      command/beat accepted this cycle when ready&(read|write)
//  port_rd_valid         out  NUM_PORTS      read beat for port i on port_rd_data
//  port_rd_data          out  DATA_WIDTH     read data, broadcast to all ports
//  ddr3_avl_ready        in   1              controller ready
//  ddr3_avl_burstbegin   out  1              first beat of command
//  ddr3_avl_size         out  SIZE_WIDTH     burst size
//  ddr3_avl_read_req     out  1              read request
//  ddr3_avl_write_req    out  1              write request
//  ddr3_avl_addr         out  ADDR_WIDTH     address
//  ddr3_avl_wr_data      out  DATA_WIDTH     write data
//  ddr3_avl_read_data_valid in 1             read data valid
//  ddr3_avl_read_data    in   DATA_WIDTH     read data
//  rd_unexpected         out  1              sticky: read data arrived with no tag pending
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, no grant, rr pointer 0, tag FIFO empty, beat count 0.
//  FSM IDLE/CMD/WBURST. IDLE: pick first requester (read|write) searching from rr_ptr
//   upward with wrap; register grant, go CMD next cycle (1-cycle arbitration latency).
//  CMD: avl outputs = granted port's signals, burstbegin=1; others' port_ready=0.
//   port_ready[g] = ddr3_avl_ready & ~(port_read[g] & tag_full).
//   Read accepted: push {g,size} into tag FIFO, rr_ptr=g+1 mod N, -> IDLE.
//   Write accepted, size<=1: rr_ptr=g+1, -> IDLE. size>1: load remaining=size-1, -> WBURST.
//   Granted port drops both requests before acceptance: release, -> IDLE, rr_ptr unchanged.
//  WBURST: burstbegin=0, addr/size held from first beat; write_req=port_write[g];
//   each accepted beat decrements remaining; at 0 rr_ptr=g+1, -> IDLE. Grant never
//   released mid-burst; port_read[g] ignored in WBURST.
//  Read and write never asserted together on avl; read_req/write_req low in IDLE.
//  size 0 treated as 1 (tag and write count); size is not otherwise checked.
//  Read return: head tag {p,s}; each read_data_valid asserts port_rd_valid[p] same cycle
//   (combinational), port_rd_data = ddr3_avl_read_data; beat_cnt++; on beat s pop, cnt=0.
//  read_data_valid with tag FIFO empty: no port_rd_valid, rd_unexpected set until reset.
//  Full uses pre-pop occupancy: push blocked when full even if popping same cycle.
//  Simultaneous push and pop when not full: occupancy unchanged, both take effect.
//  ddr3_avl_ready low: hold all avl outputs stable, no state change.
// TESTING
//  Ports 0,1 both read size 2 every cycle -> commands alternate 0,1,0,1; rd_valid routed per tag.
//  Port1 write size 4 while port0 reads -> 4 consecutive port1 beats, burstbegin on beat 1 only.
//  ready low 3 cycles mid-burst -> addr/data/size held; remaining unchanged.
//  16 outstanding reads, no returns -> 17th read port_ready=0 until first tag popped.
//  read_data_valid with empty FIFO -> no port_rd_valid; rd_unexpected=1 after, holds.
//  Reset asserted in WBURST -> next cycle all avl outputs 0, FSM IDLE, FIFO empty.

Source files
------------

// File: rtl/ddr3_avl_arbiter.sv
// N-port Avalon-MM arbiter in front of the DDR3 controller local interface.
// Round-robin command grant, write bursts hold the grant until the last beat,
// and read commands leave a {port,size} tag so returning read beats can be
// steered back to the port that issued them.
//
// Handshake: a port command or write beat is taken on a rising clock edge
// when port_ready[i] & (port_read[i] | port_write[i]) is high; on the avl side
// a command/beat is taken when ddr3_avl_ready & (read_req | write_req) is high.
// A requester holds its request and payload stable until it is taken.
//
// dbg_state encoding: 0 = IDLE, 1 = CMD, 2 = WBURST.
module ddr3_avl_arbiter #(
    parameter int NUM_PORTS  = 2,
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 26,
    parameter int SIZE_WIDTH = 3,
    parameter int TAG_DEPTH  = 16
) (
    input  logic                             ddr3_clk,
    input  logic                             ddr3_reset_n,
    input  logic [NUM_PORTS-1:0]             port_read,
    input  logic [NUM_PORTS-1:0]             port_write,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  port_addr,
    input  logic [NUM_PORTS*SIZE_WIDTH-1:0]  port_size,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  port_wr_data,
    output logic [NUM_PORTS-1:0]             port_ready,
    output logic [NUM_PORTS-1:0]             port_rd_valid,
    output logic [DATA_WIDTH-1:0]            port_rd_data,
    input  logic                             ddr3_avl_ready,
    output logic                             ddr3_avl_burstbegin,
    output logic [SIZE_WIDTH-1:0]            ddr3_avl_size,
    output logic                             ddr3_avl_read_req,
    output logic                             ddr3_avl_write_req,
    output logic [ADDR_WIDTH-1:0]            ddr3_avl_addr,
    output logic [DATA_WIDTH-1:0]            ddr3_avl_wr_data,
    input  logic                             ddr3_avl_read_data_valid,
    input  logic [DATA_WIDTH-1:0]            ddr3_avl_read_data,
    output logic                             rd_unexpected,
    output logic [1:0]                       dbg_state
);

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int TW = $clog2(TAG_DEPTH);
    localparam int CW = TW + 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CMD    = 2'd1,
        ST_WBURST = 2'd2
    } state_t;

    state_t                  state;
    logic [PW-1:0]           grant;
    logic [PW-1:0]           rr_ptr;
    logic [SIZE_WIDTH-1:0]   remaining;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [SIZE_WIDTH-1:0]   size_q;

    // tag FIFO: one entry per outstanding read command
    logic [PW+SIZE_WIDTH-1:0] tag_mem [TAG_DEPTH];
    logic [TW-1:0]            tag_wr_ptr;
    logic [TW-1:0]            tag_rd_ptr;
    logic [CW-1:0]            tag_count;
    logic [SIZE_WIDTH-1:0]    beat_cnt;
    logic                     tag_full;
    logic                     tag_empty;
    logic [PW-1:0]            head_port;
    logic [SIZE_WIDTH-1:0]    head_size;
    logic                     tag_push;
    logic                     tag_pop;

    // granted port's request and payload
    logic                    g_read;
    logic                    g_write;
    logic [ADDR_WIDTH-1:0]   g_addr;
    logic [SIZE_WIDTH-1:0]   g_size;
    logic [SIZE_WIDTH-1:0]   g_size_eff;
    logic [DATA_WIDTH-1:0]   g_data;
    logic [PW-1:0]           grant_next;

    logic                    rd_req;
    logic                    wr_req;
    logic                    pick_valid;
    logic [PW-1:0]           pick;
    logic [PW-1:0]           idx;

    assign g_read     = port_read[grant];
    assign g_write    = port_write[grant];
    assign g_addr     = port_addr[int'(grant)*ADDR_WIDTH +: ADDR_WIDTH];
    assign g_size     = port_size[int'(grant)*SIZE_WIDTH +: SIZE_WIDTH];
    assign g_data     = port_wr_data[int'(grant)*DATA_WIDTH +: DATA_WIDTH];
    // a zero burst size moves one beat
    assign g_size_eff = (g_size == '0) ? SIZE_WIDTH'(1) : g_size;
    assign grant_next = (grant == PW'(NUM_PORTS - 1)) ? '0 : grant + 1'b1;

    // a read is never issued without a free tag; read wins if a port raises both
    assign rd_req = (state == ST_CMD) & g_read & ~tag_full;
    assign wr_req = (state == ST_CMD) & g_write & ~g_read;

    assign tag_full  = (tag_count == CW'(TAG_DEPTH));
    assign tag_empty = (tag_count == '0);
    assign head_port = tag_mem[tag_rd_ptr][PW+SIZE_WIDTH-1:SIZE_WIDTH];
    assign head_size = tag_mem[tag_rd_ptr][SIZE_WIDTH-1:0];
    assign tag_push  = rd_req & ddr3_avl_ready;
    assign tag_pop   = ddr3_avl_read_data_valid & ~tag_empty & (beat_cnt + 1'b1 == head_size);

    assign port_rd_data = ddr3_avl_read_data;
    assign dbg_state    = state;

    // round-robin pick: first requester at or after rr_ptr, wrapping
    always_comb begin
        pick_valid = 1'b0;
        pick       = rr_ptr;
        idx        = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (int'(rr_ptr) + k >= NUM_PORTS) idx = PW'(int'(rr_ptr) + k - NUM_PORTS);
            else                               idx = PW'(int'(rr_ptr) + k);
            if (port_read[idx] | port_write[idx]) begin
                pick_valid = 1'b1;
                pick       = idx;
            end
        end
    end

    // avl command outputs and port acceptance follow the granted port
    always_comb begin
        ddr3_avl_read_req   = 1'b0;
        ddr3_avl_write_req  = 1'b0;
        ddr3_avl_burstbegin = 1'b0;
        ddr3_avl_addr       = '0;
        ddr3_avl_size       = '0;
        ddr3_avl_wr_data    = '0;
        port_ready          = '0;
        case (state)
            ST_CMD: begin
                ddr3_avl_read_req   = rd_req;
                ddr3_avl_write_req  = wr_req;
                ddr3_avl_burstbegin = rd_req | wr_req;
                ddr3_avl_addr       = g_addr;
                ddr3_avl_size       = g_size;
                ddr3_avl_wr_data    = g_data;
                port_ready[grant]   = ddr3_avl_ready & ~(g_read & tag_full);
            end
            ST_WBURST: begin
                ddr3_avl_write_req  = g_write;
                ddr3_avl_addr       = addr_q;
                ddr3_avl_size       = size_q;
                ddr3_avl_wr_data    = g_data;
                port_ready[grant]   = ddr3_avl_ready;
            end
            default: ;
        endcase
    end

    // read return steering to the port at the head of the tag FIFO
    always_comb begin
        port_rd_valid = '0;
        if (ddr3_avl_read_data_valid & ~tag_empty) port_rd_valid[head_port] = 1'b1;
    end

    // arbitration FSM; frozen whenever the controller is not ready
    always_ff @(posedge ddr3_clk or negedge ddr3_reset_n) begin
        if (!ddr3_reset_n) begin
            state     <= ST_IDLE;
            grant     <= '0;
            rr_ptr    <= '0;
            remaining <= '0;
            addr_q    <= '0;
            size_q    <= '0;
        end else if (ddr3_avl_ready) begin
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        grant <= pick;
                        state <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (rd_req) begin
                        rr_ptr <= grant_next;
                        state  <= ST_IDLE;
                    end else if (wr_req) begin
                        if (g_size_eff <= SIZE_WIDTH'(1)) begin
                            rr_ptr <= grant_next;
                            state  <= ST_IDLE;
                        end else begin
                            remaining <= g_size_eff - 1'b1;
                            addr_q    <= g_addr;
                            size_q    <= g_size;
                            state     <= ST_WBURST;
                        end
                    end else if (!g_read && !g_write) begin
                        // requester withdrew before acceptance: release, keep rr_ptr
                        state <= ST_IDLE;
                    end
                end
                ST_WBURST: begin
                    if (g_write) begin
                        remaining <= remaining - 1'b1;
                        if (remaining == SIZE_WIDTH'(1)) begin
                            rr_ptr <= grant_next;
                            state  <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // tag FIFO pointers, occupancy and read-beat counter
    always_ff @(posedge ddr3_clk or negedge ddr3_reset_n) begin
        if (!ddr3_reset_n) begin
            tag_wr_ptr    <= '0;
            tag_rd_ptr    <= '0;
            tag_count     <= '0;
            beat_cnt      <= '0;
            rd_unexpected <= 1'b0;
        end else begin
            if (tag_push) tag_wr_ptr <= tag_wr_ptr + 1'b1;
            if (ddr3_avl_read_data_valid & ~tag_empty) begin
                if (tag_pop) begin
                    tag_rd_ptr <= tag_rd_ptr + 1'b1;
                    beat_cnt   <= '0;
                end else begin
                    beat_cnt   <= beat_cnt + 1'b1;
                end
            end
            case ({tag_push, tag_pop})
                2'b10:   tag_count <= tag_count + 1'b1;
                2'b01:   tag_count <= tag_count - 1'b1;
                default: ;
            endcase
            if (ddr3_avl_read_data_valid & tag_empty) rd_unexpected <= 1'b1;
        end
    end

    // tag storage written on read command acceptance
    always_ff @(posedge ddr3_clk) begin
        if (tag_push) tag_mem[tag_wr_ptr] <= {grant, g_size_eff};
    end

endmodule

// File: tb/tb_ddr3_avl_arbiter.sv
// Bench for ddr3_avl_arbiter: bus-level masters, a transaction scoreboard of
// expected avl beats in grant order, a read-tag model, and directed scenarios.
module tb_ddr3_avl_arbiter;

    localparam int NP = 2;
    localparam int DW = 128;
    localparam int AW = 26;
    localparam int SW = 3;
    localparam int TD = 16;

    logic                 ddr3_clk;
    logic                 ddr3_reset_n;
    logic [NP-1:0]        port_read;
    logic [NP-1:0]        port_write;
    logic [NP*AW-1:0]     port_addr;
    logic [NP*SW-1:0]     port_size;
    logic [NP*DW-1:0]     port_wr_data;
    logic [NP-1:0]        port_ready;
    logic [NP-1:0]        port_rd_valid;
    logic [DW-1:0]        port_rd_data;
    logic                 ddr3_avl_ready;
    logic                 ddr3_avl_burstbegin;
    logic [SW-1:0]        ddr3_avl_size;
    logic                 ddr3_avl_read_req;
    logic                 ddr3_avl_write_req;
    logic [AW-1:0]        ddr3_avl_addr;
    logic [DW-1:0]        ddr3_avl_wr_data;
    logic                 ddr3_avl_read_data_valid;
    logic [DW-1:0]        ddr3_avl_read_data;
    logic                 rd_unexpected;
    logic [1:0]           dbg_state;

    ddr3_avl_arbiter #(
        .NUM_PORTS(NP), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SIZE_WIDTH(SW), .TAG_DEPTH(TD)
    ) dut (
        .ddr3_clk                 (ddr3_clk),
        .ddr3_reset_n             (ddr3_reset_n),
        .port_read                (port_read),
        .port_write               (port_write),
        .port_addr                (port_addr),
        .port_size                (port_size),
        .port_wr_data             (port_wr_data),
        .port_ready               (port_ready),
        .port_rd_valid            (port_rd_valid),
        .port_rd_data             (port_rd_data),
        .ddr3_avl_ready           (ddr3_avl_ready),
        .ddr3_avl_burstbegin      (ddr3_avl_burstbegin),
        .ddr3_avl_size            (ddr3_avl_size),
        .ddr3_avl_read_req        (ddr3_avl_read_req),
        .ddr3_avl_write_req       (ddr3_avl_write_req),
        .ddr3_avl_addr            (ddr3_avl_addr),
        .ddr3_avl_wr_data         (ddr3_avl_wr_data),
        .ddr3_avl_read_data_valid (ddr3_avl_read_data_valid),
        .ddr3_avl_read_data       (ddr3_avl_read_data),
        .rd_unexpected            (rd_unexpected),
        .dbg_state                (dbg_state)
    );

    typedef struct {
        bit             wr;
        logic [AW-1:0]  addr;
        logic [SW-1:0]  size;
        logic [DW-1:0]  data;
    } cmd_t;

    typedef struct {
        bit             wr;
        int             port;
        logic [AW-1:0]  addr;
        logic [SW-1:0]  size;
        logic [DW-1:0]  data;
        bit             bb;
    } beat_t;

    typedef struct {
        int port;
        int beats;
    } tag_t;

    int     checks   = 0;
    int     failures = 0;

    cmd_t   cmd_q [NP][$];
    cmd_t   cur [NP];
    bit     cur_v [NP];
    int     beat_idx [NP];
    logic [NP-1:0] acc;
    int     flush_req  = 0;
    int     flush_seen = 0;

    beat_t  exp_q[$];
    tag_t   tag_m[$];
    int     tag_beats_m = 0;
    bit     unexp_m     = 0;

    // ---------------- clock / reset ----------------
    initial begin
        ddr3_clk = 1'b0;
        forever #5 ddr3_clk = ~ddr3_clk;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int eff_size(input logic [SW-1:0] s);
        return (s == '0) ? 1 : int'(s);
    endfunction

    task automatic push_cmd(input int p, input bit wr, input logic [AW-1:0] a,
                            input logic [SW-1:0] s, input logic [DW-1:0] d);
        cmd_t c;
        c.wr = wr; c.addr = a; c.size = s; c.data = d;
        cmd_q[p].push_back(c);
    endtask

    task automatic push_exp(input bit wr, input int p, input logic [AW-1:0] a,
                            input logic [SW-1:0] s, input logic [DW-1:0] d, input bit bb);
        beat_t b;
        b.wr = wr; b.port = p; b.addr = a; b.size = s; b.data = d; b.bb = bb;
        exp_q.push_back(b);
    endtask

    function automatic bit masters_idle();
        for (int p = 0; p < NP; p++)
            if (cur_v[p] || cmd_q[p].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_quiet(input string name, input int budget);
        int n = 0;
        @(negedge ddr3_clk);
        while (!(exp_q.size() == 0 && masters_idle() && dbg_state == 2'd0) && n < budget) begin
            @(negedge ddr3_clk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            failures++;
            $display("FAIL %s: timeout, %0d beats still expected", name, exp_q.size());
        end
    endtask

    task automatic return_beats(input int n, input logic [DW-1:0] base,
                                input logic [NP-1:0] first_exp, input string name);
        for (int i = 0; i < n; i++) begin
            @(posedge ddr3_clk); #1;
            ddr3_avl_read_data_valid = 1'b1;
            ddr3_avl_read_data       = base + DW'(i);
            if (i == 0) begin
                @(negedge ddr3_clk);
                check(name, port_rd_valid, first_exp);
            end
        end
        @(posedge ddr3_clk); #1;
        ddr3_avl_read_data_valid = 1'b0;
        ddr3_avl_read_data       = '0;
    endtask

    // ---------------- masters (all ports) ----------------
    initial begin
        port_read    = '0;
        port_write   = '0;
        port_addr    = '0;
        port_size    = '0;
        port_wr_data = '0;
        for (int p = 0; p < NP; p++) begin
            cur_v[p]    = 1'b0;
            beat_idx[p] = 0;
        end
        forever begin
            @(negedge ddr3_clk);
            acc = port_ready & (port_read | port_write);
            @(posedge ddr3_clk); #1;
            if (flush_req != flush_seen) begin
                flush_seen = flush_req;
                acc        = '0;
                for (int p = 0; p < NP; p++) begin
                    cmd_q[p].delete();
                    cur_v[p] = 1'b0;
                end
            end
            for (int p = 0; p < NP; p++) begin
                if (acc[p] && cur_v[p]) begin
                    if (!cur[p].wr) cur_v[p] = 1'b0;
                    else begin
                        beat_idx[p]++;
                        if (beat_idx[p] >= eff_size(cur[p].size)) cur_v[p] = 1'b0;
                    end
                end
                if (!cur_v[p] && cmd_q[p].size() > 0) begin
                    cur[p]      = cmd_q[p].pop_front();
                    cur_v[p]    = 1'b1;
                    beat_idx[p] = 0;
                end
                port_read[p]             = cur_v[p] & !cur[p].wr;
                port_write[p]            = cur_v[p] & cur[p].wr;
                port_addr[p*AW +: AW]    = cur_v[p] ? cur[p].addr : '0;
                port_size[p*SW +: SW]    = cur_v[p] ? cur[p].size : '0;
                port_wr_data[p*DW +: DW] = (cur_v[p] && cur[p].wr) ? cur[p].data + DW'(beat_idx[p]) : '0;
            end
        end
    end

    // ---------------- scoreboard / compare process ----------------
    initial begin
        beat_t          e;
        logic [NP-1:0]  exp_rdv;
        forever begin
            @(negedge ddr3_clk);
            if (!ddr3_reset_n) begin
                exp_q.delete();
                tag_m.delete();
                tag_beats_m = 0;
                unexp_m     = 1'b0;
                continue;
            end
            check("rw_exclusive", ddr3_avl_read_req & ddr3_avl_write_req, 1'b0);
            check("rd_unexpected", rd_unexpected, unexp_m);
            if (tag_m.size() == TD) check("no_read_when_full", ddr3_avl_read_req, 1'b0);

            // read return routing from the outstanding-read model
            exp_rdv = '0;
            if (ddr3_avl_read_data_valid) begin
                if (tag_m.size() == 0) unexp_m = 1'b1;
                else begin
                    exp_rdv[tag_m[0].port] = 1'b1;
                    tag_beats_m++;
                    if (tag_beats_m == tag_m[0].beats) begin
                        void'(tag_m.pop_front());
                        tag_beats_m = 0;
                    end
                end
            end
            check("rd_valid", port_rd_valid, exp_rdv);
            if (exp_rdv != '0) check("rd_data", port_rd_data, ddr3_avl_read_data);

            // avl beat accepted at the coming edge: must be next in grant order
            if (ddr3_avl_ready && (ddr3_avl_read_req || ddr3_avl_write_req)) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_beat: wr=%0b addr=%0h", ddr3_avl_write_req, ddr3_avl_addr);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_is_write", ddr3_avl_write_req, e.wr);
                    check("beat_addr", ddr3_avl_addr, e.addr);
                    check("beat_size", ddr3_avl_size, e.size);
                    check("beat_burstbegin", ddr3_avl_burstbegin, e.bb);
                    check("beat_port_accept", port_ready & (port_read | port_write), NP'(1) << e.port);
                    if (e.wr) check("beat_wr_data", ddr3_avl_wr_data, e.data);
                    else tag_m.push_back('{port: e.port, beats: eff_size(e.size)});
                end
            end
        end
    end

    // ---------------- directed scenarios ----------------
    initial begin
        int n;
        ddr3_reset_n             = 1'b0;
        ddr3_avl_ready           = 1'b1;
        ddr3_avl_read_data_valid = 1'b0;
        ddr3_avl_read_data       = '0;

        // reset state
        repeat (2) @(negedge ddr3_clk);
        check("rst_read_req", ddr3_avl_read_req, 1'b0);
        check("rst_write_req", ddr3_avl_write_req, 1'b0);
        check("rst_burstbegin", ddr3_avl_burstbegin, 1'b0);
        check("rst_addr", ddr3_avl_addr, '0);
        check("rst_size", ddr3_avl_size, '0);
        check("rst_port_ready", port_ready, '0);
        check("rst_rd_valid", port_rd_valid, '0);
        check("rst_unexpected", rd_unexpected, 1'b0);
        check("rst_state", dbg_state, 2'd0);
        @(posedge ddr3_clk); #1;
        ddr3_reset_n = 1'b1;

        // single read: one idle cycle of arbitration before the command appears
        @(negedge ddr3_clk);
        push_cmd(0, 0, 26'h100, 3'd2, '0);
        push_exp(0, 0, 26'h100, 3'd2, '0, 1);
        @(negedge ddr3_clk);
        check("lat_idle_no_req", ddr3_avl_read_req, 1'b0);
        @(negedge ddr3_clk);
        check("lat_cmd_read_req", ddr3_avl_read_req, 1'b1);
        check("lat_cmd_addr", ddr3_avl_addr, 26'h100);
        check("lat_cmd_bb", ddr3_avl_burstbegin, 1'b1);
        wait_quiet("single_read", 50);
        return_beats(2, 128'h1000, 2'b01, "single_read_route");

        // both ports read size 2 continuously: rr_ptr is 1 so port 1 leads
        push_cmd(0, 0, 26'h10, 3'd2, '0);
        push_cmd(0, 0, 26'h12, 3'd2, '0);
        push_cmd(0, 0, 26'h14, 3'd2, '0);
        push_cmd(1, 0, 26'h20, 3'd2, '0);
        push_cmd(1, 0, 26'h22, 3'd2, '0);
        push_cmd(1, 0, 26'h24, 3'd2, '0);
        push_exp(0, 1, 26'h20, 3'd2, '0, 1);
        push_exp(0, 0, 26'h10, 3'd2, '0, 1);
        push_exp(0, 1, 26'h22, 3'd2, '0, 1);
        push_exp(0, 0, 26'h12, 3'd2, '0, 1);
        push_exp(0, 1, 26'h24, 3'd2, '0, 1);
        push_exp(0, 0, 26'h14, 3'd2, '0, 1);
        wait_quiet("alternate_reads", 100);
        return_beats(12, 128'h2000, 2'b10, "alternate_first_route");

        // port 1 write burst of 4 while port 0 reads; ready low mid-burst
        push_cmd(1, 1, 26'h300, 3'd4, 128'hA0);
        push_cmd(0, 0, 26'h40, 3'd1, '0);
        push_cmd(0, 0, 26'h41, 3'd1, '0);
        push_exp(1, 1, 26'h300, 3'd4, 128'hA0, 1);
        push_exp(1, 1, 26'h300, 3'd4, 128'hA1, 0);
        push_exp(1, 1, 26'h300, 3'd4, 128'hA2, 0);
        push_exp(1, 1, 26'h300, 3'd4, 128'hA3, 0);
        push_exp(0, 0, 26'h40, 3'd1, '0, 1);
        push_exp(0, 0, 26'h41, 3'd1, '0, 1);
        n = 0;
        do begin
            @(negedge ddr3_clk);
            n++;
        end while (!(ddr3_avl_write_req && ddr3_avl_ready && !ddr3_avl_burstbegin &&
                     ddr3_avl_wr_data == 128'hA1) && n < 50);
        check("burst_second_beat_seen", n < 50, 1'b1);
        @(posedge ddr3_clk); #1;
        ddr3_avl_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge ddr3_clk);
            check("hold_write_req", ddr3_avl_write_req, 1'b1);
            check("hold_addr", ddr3_avl_addr, 26'h300);
            check("hold_size", ddr3_avl_size, 3'd4);
            check("hold_wr_data", ddr3_avl_wr_data, 128'hA2);
            check("hold_bb", ddr3_avl_burstbegin, 1'b0);
            check("hold_state_wburst", dbg_state, 2'd2);
            check("hold_port1_ready", port_ready, 2'b00);
        end
        @(posedge ddr3_clk); #1;
        ddr3_avl_ready = 1'b1;
        wait_quiet("write_burst", 100);
        return_beats(2, 128'h3000, 2'b01, "burst_reads_route");

        // fill all 16 tags with no return; the 17th read must stall
        for (int i = 0; i < 17; i++) begin
            push_cmd(0, 0, 26'h500 + AW'(i), 3'd1, '0);
            push_exp(0, 0, 26'h500 + AW'(i), 3'd1, '0, 1);
        end
        n = 0;
        while (tag_m.size() != TD && n < 200) begin
            @(negedge ddr3_clk);
            n++;
        end
        check("tags_filled", tag_m.size(), TD);
        repeat (3) @(negedge ddr3_clk);
        check("full_port_ready", port_ready[0], 1'b0);
        check("full_no_read_req", ddr3_avl_read_req, 1'b0);
        check("full_state_cmd", dbg_state, 2'd1);
        check("full_one_left", exp_q.size(), 1);
        return_beats(1, 128'h4000, 2'b01, "full_first_pop");
        wait_quiet("seventeenth_read", 50);
        return_beats(16, 128'h4100, 2'b01, "full_drain");

        // read data with no outstanding tag
        @(posedge ddr3_clk); #1;
        ddr3_avl_read_data_valid = 1'b1;
        ddr3_avl_read_data       = 128'hDEAD;
        @(negedge ddr3_clk);
        check("unexp_no_rd_valid", port_rd_valid, 2'b00);
        check("unexp_not_yet", rd_unexpected, 1'b0);
        @(posedge ddr3_clk); #1;
        ddr3_avl_read_data_valid = 1'b0;
        ddr3_avl_read_data       = '0;
        @(negedge ddr3_clk);
        check("unexp_set", rd_unexpected, 1'b1);
        repeat (3) @(negedge ddr3_clk);
        check("unexp_sticky", rd_unexpected, 1'b1);

        // size 0 handled as a single beat for both reads and writes
        push_cmd(0, 1, 26'h600, 3'd0, 128'h55);
        push_cmd(1, 0, 26'h700, 3'd0, '0);
        push_exp(0, 1, 26'h700, 3'd0, '0, 1);
        push_exp(1, 0, 26'h600, 3'd0, 128'h55, 1);
        wait_quiet("size_zero", 50);
        return_beats(1, 128'h6000, 2'b10, "size_zero_route");

        // reset during a write burst with a read tag outstanding
        push_cmd(0, 0, 26'h800, 3'd1, '0);
        push_exp(0, 0, 26'h800, 3'd1, '0, 1);
        wait_quiet("pre_reset_read", 50);
        push_cmd(1, 1, 26'h900, 3'd4, 128'hB0);
        push_exp(1, 1, 26'h900, 3'd4, 128'hB0, 1);
        push_exp(1, 1, 26'h900, 3'd4, 128'hB1, 0);
        push_exp(1, 1, 26'h900, 3'd4, 128'hB2, 0);
        push_exp(1, 1, 26'h900, 3'd4, 128'hB3, 0);
        n = 0;
        do begin
            @(negedge ddr3_clk);
            n++;
        end while (dbg_state != 2'd2 && n < 50);
        check("reached_wburst", dbg_state, 2'd2);
        flush_req++;
        @(posedge ddr3_clk); #1;
        ddr3_reset_n = 1'b0;
        @(negedge ddr3_clk);
        check("mid_rst_write_req", ddr3_avl_write_req, 1'b0);
        check("mid_rst_read_req", ddr3_avl_read_req, 1'b0);
        check("mid_rst_bb", ddr3_avl_burstbegin, 1'b0);
        check("mid_rst_addr", ddr3_avl_addr, '0);
        check("mid_rst_size", ddr3_avl_size, '0);
        check("mid_rst_wr_data", ddr3_avl_wr_data, '0);
        check("mid_rst_state", dbg_state, 2'd0);
        check("mid_rst_unexp_clr", rd_unexpected, 1'b0);
        @(posedge ddr3_clk); #1;
        ddr3_reset_n = 1'b1;
        @(posedge ddr3_clk); #1;
        ddr3_avl_read_data_valid = 1'b1;
        ddr3_avl_read_data       = 128'hBEEF;
        @(negedge ddr3_clk);
        check("post_rst_fifo_empty", port_rd_valid, 2'b00);
        @(posedge ddr3_clk); #1;
        ddr3_avl_read_data_valid = 1'b0;
        ddr3_avl_read_data       = '0;
        @(negedge ddr3_clk);
        check("post_rst_unexp", rd_unexpected, 1'b1);

        // rr pointer back at 0 after reset: port 0 wins a tie
        push_cmd(0, 0, 26'hA00, 3'd1, '0);
        push_cmd(1, 0, 26'hA10, 3'd1, '0);
        push_exp(0, 0, 26'hA00, 3'd1, '0, 1);
        push_exp(0, 1, 26'hA10, 3'd1, '0, 1);
        wait_quiet("post_rst_rr", 50);
        return_beats(2, 128'h7000, 2'b01, "post_rst_route");

        repeat (3) @(negedge ddr3_clk);
        check("final_exp_empty", exp_q.size(), 0);
        check("final_tags_empty", tag_m.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
